// File: rtl/wb_buffer.sv
// wb_buffer: in-order dirty-line write-back FIFO; WB_BUFFER_FWD_EN enables youngest-match lookup forwarding.
module wb_buffer #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int IN_PORT_NUM = 2,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [IN_PORT_NUM-1:0] evict_in,
  input  logic [IN_PORT_NUM-1:0][ADDR_WIDTH-1:0] evicted_addr_in,
  input  logic [IN_PORT_NUM-1:0][DATA_WIDTH-1:0] evicted_data_in,
  input  logic [IN_PORT_NUM-1:0] evicted_dirty_in,
  output logic enq_ready,
  output logic mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic mem_req_ready,
  input  logic [ADDR_WIDTH-1:0] lu_addr,
  output logic lu_hit,
  output logic [DATA_WIDTH-1:0] lu_data,
  output logic empty,
  output logic overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LIMIT = (PW+1)'(DEPTH - IN_PORT_NUM);
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0] head, tail;
  logic [PW:0] count, n_enq;
  logic [IN_PORT_NUM-1:0] qual;
  logic [IN_PORT_NUM-1:0][PW-1:0] wr_idx;
  logic pop;
  assign qual = evict_in & evicted_dirty_in;
  assign enq_ready = count <= LIMIT;
  assign pop = mem_req_valid & mem_req_ready;
  assign mem_req_valid = count != '0;
  assign empty = count == '0;
  assign mem_req_addr = vld_q[head] ? addr_q[head] : '0;
  assign mem_req_data = vld_q[head] ? data_q[head] : '0;
  // Qualifying ports pack into consecutive slots, lower port index is older.
  always_comb begin
    n_enq = '0;
    for (int p = 0; p < IN_PORT_NUM; p++) begin
      wr_idx[p] = tail + n_enq[PW-1:0];
      n_enq = n_enq + (PW+1)'(qual[p]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      vld_q <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        vld_q[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (enq_ready) begin
        for (int p = 0; p < IN_PORT_NUM; p++) begin
          if (qual[p]) begin
            addr_q[wr_idx[p]] <= evicted_addr_in[p];
            data_q[wr_idx[p]] <= evicted_data_in[p];
            vld_q[wr_idx[p]] <= 1'b1;
          end
        end
        tail <= tail + n_enq[PW-1:0];
      end
      count <= count - (PW+1)'(pop) + (enq_ready ? n_enq : '0);
      overflow <= overflow | (|qual & ~enq_ready);
    end
  end
`ifdef WB_BUFFER_FWD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    lu_hit = 1'b0;
    lu_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[head + PW'(i)] && addr_q[head + PW'(i)] == lu_addr) begin
        lu_hit = 1'b1;
        lu_data = data_q[head + PW'(i)];
      end
    end
  end
`else
  logic unused_lu;
  assign unused_lu = ^lu_addr;
  assign lu_hit = 1'b0;
  assign lu_data = '0;
`endif
endmodule
